// File: rtl/calc_sequencer.sv
// RPN calculator sequencer: pushes switch operands onto an external stack and
// runs pop-B / pop-A / execute / push-result through an external combinational ALU.
module calc_sequencer #(
  parameter int DEPTH = 16,
  parameter int CW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_req,
  input  logic          op_req,
  input  logic [3:0]    op,
  input  logic [15:0]   switches,
  input  logic [31:0]   mem_data_out,
  input  logic [31:0]   alu_y,
  input  logic          alu_ovf,
  output logic [31:0]   mem_data_in,
  output logic          mem_push,
  output logic          mem_pop,
  output logic [31:0]   alu_a,
  output logic [31:0]   alu_b,
  output logic [3:0]    alu_op,
  output logic [31:0]   result,
  output logic          busy,
  output logic [1:0]    err_code,
  output logic [CW-1:0] count
);

  typedef enum logic [2:0] {IDLE, POP_B, LAT_B, POP_A, LAT_A, EXEC, PUSH} state_e;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_UNDF = 2'b01;
  localparam logic [1:0] ERR_FULL = 2'b10;
  localparam logic [1:0] ERR_OVF  = 2'b11;

  state_e        state_q, state_d;
  logic [31:0]   a_q, a_d, b_q, b_d, din_q, din_d, res_q, res_d;
  logic [3:0]    op_q, op_d;
  logic [1:0]    err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc, cnt_dec;
  logic          ipush_q, ipush_d;

  // Saturating occupancy arithmetic
  assign cnt_inc = (cnt_q == CW'(DEPTH)) ? cnt_q : cnt_q + CW'(1);
  assign cnt_dec = (cnt_q == '0)         ? cnt_q : cnt_q - CW'(1);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    din_d   = din_q;
    res_d   = res_q;
    op_d    = op_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    ipush_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        // op_req has priority; a simultaneous push_req is dropped
        if (op_req) begin
          if (cnt_q >= CW'(2)) begin
            op_d    = op;
            err_d   = ERR_NONE;
            state_d = POP_B;
          end else begin
            err_d = ERR_UNDF;
          end
        end else if (push_req) begin
          if (cnt_q < CW'(DEPTH)) begin
            ipush_d = 1'b1;
            din_d   = {16'h0, switches};
            res_d   = {16'h0, switches};
            cnt_d   = cnt_inc;
            err_d   = ERR_NONE;
          end else begin
            err_d = ERR_FULL;
          end
        end
      end
      POP_B: begin cnt_d = cnt_dec; state_d = LAT_B; end
      LAT_B: begin b_d = mem_data_out; state_d = POP_A; end
      POP_A: begin cnt_d = cnt_dec; state_d = LAT_A; end
      LAT_A: begin a_d = mem_data_out; state_d = EXEC; end
      EXEC: begin
        din_d = alu_y;
        if (alu_ovf) err_d = ERR_OVF;
        state_d = PUSH;
      end
      PUSH: begin
        res_d   = din_q;
        cnt_d   = cnt_inc;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      din_q   <= '0;
      res_q   <= '0;
      op_q    <= '0;
      err_q   <= ERR_NONE;
      cnt_q   <= '0;
      ipush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      din_q   <= din_d;
      res_q   <= res_d;
      op_q    <= op_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      ipush_q <= ipush_d;
    end
  end

  // Operand pushes strobe from a register; result pushes and pops decode state
  assign mem_push    = ipush_q | (state_q == PUSH);
  assign mem_pop     = (state_q == POP_B) | (state_q == POP_A);
  assign mem_data_in = din_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_op      = op_q;
  assign result      = res_q;
  assign busy        = (state_q != IDLE);
  assign err_code    = err_q;
  assign count       = cnt_q;

endmodule
